// File: rtl/ground_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ground_pkg
// Brief    : Shared types, LFSR constants and seed helper for ground lines.
// Revision : 1.0 - initial release
// ============================================================================
package ground_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_GAP   = 2'd2
  } ground_state_e;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_FALLBACK = 16'hACE1;

  // An all-zero seed would lock the Galois LFSR, so it is swapped out.
  function automatic logic [15:0] effective_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? SEED_FALLBACK : seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ground_scroller_if.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroller_if
// Brief    : Scroll control inputs and ground line outputs of one scroller.
// Revision : 1.0 - initial release
// ============================================================================
interface ground_scroller_if #(
  parameter int WIDTH = 640
);

  logic             enable_board;
  logic             step;
  logic [WIDTH-1:0] line_o;
  logic             in_gap;
  logic [15:0]      scroll_cnt;

  modport master (
    output enable_board,
    output step,
    input  line_o,
    input  in_gap,
    input  scroll_cnt
  );

  modport slave (
    input  enable_board,
    input  step,
    output line_o,
    output in_gap,
    output scroll_cnt
  );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit right-shifting Galois LFSR with zero-safe seed load.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import ground_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] value
);

  logic [15:0] r_value;
  logic [15:0] w_next;

  assign w_next = {1'b0, r_value[15:1]} ^ (r_value[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_value <= effective_seed(seed);
    end else if (adv) begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/ground_scroller.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroller
// Brief    : Scrolling ground occupancy line with LFSR-driven solid/gap runs.
// Revision : 1.0 - initial release
// ============================================================================
module ground_scroller
  import ground_pkg::*;
#(
  parameter int          WIDTH     = 640,
  parameter logic [15:0] SEED      = 16'h0001,
  parameter int          LEAD_IN   = 160,
  parameter int          MIN_SOLID = 24,
  parameter int          MIN_GAP   = 8
) (
  input  logic               clk,
  input  logic               reset,
  ground_scroller_if.slave   bus
);

  localparam logic [1:0] C_ST_IDLE  = ST_IDLE;
  localparam logic [1:0] C_ST_SOLID = ST_SOLID;
  localparam logic [1:0] C_ST_GAP   = ST_GAP;

  localparam logic [7:0] C_LEAD_M1   = 8'(LEAD_IN - 1);
  localparam logic [7:0] C_MIN_SOLID = 8'(MIN_SOLID);
  localparam logic [7:0] C_MIN_GAP   = 8'(MIN_GAP);

  logic [WIDTH-1:0] r_line;
  logic [1:0]       r_state;
  logic [7:0]       r_run_cnt;
  logic [15:0]      r_scroll_cnt;
  logic             r_in_gap;

  logic        w_accept;
  logic        w_new_bit;
  logic [15:0] w_lfsr;
  logic [7:0]  w_gap_len;
  logic [7:0]  w_solid_len;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_run_nxt;

  assign w_accept = bus.step & bus.enable_board;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .adv   (w_accept),
    .value (w_lfsr)
  );

  // Segment lengths use the LFSR value before this step's advance.
  assign w_gap_len   = C_MIN_GAP   + {4'b0000, w_lfsr[3:0]};
  assign w_solid_len = C_MIN_SOLID + {2'b00,   w_lfsr[5:0]};
  assign w_new_bit   = (r_state != C_ST_GAP);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    case (r_state)
      C_ST_IDLE: begin
        if (LEAD_IN == 1) begin
          w_state_nxt = C_ST_GAP;
          w_run_nxt   = w_gap_len;
        end else begin
          w_state_nxt = C_ST_SOLID;
          w_run_nxt   = C_LEAD_M1;
        end
      end
      C_ST_SOLID: begin
        if (r_run_cnt > 8'd1) begin
          w_run_nxt = r_run_cnt - 8'd1;
        end else begin
          w_state_nxt = C_ST_GAP;
          w_run_nxt   = w_gap_len;
        end
      end
      C_ST_GAP: begin
        if (r_run_cnt > 8'd1) begin
          w_run_nxt = r_run_cnt - 8'd1;
        end else begin
          w_state_nxt = C_ST_SOLID;
          w_run_nxt   = w_solid_len;
        end
      end
      default: begin
        w_state_nxt = C_ST_IDLE;
        w_run_nxt   = 8'd0;
      end
    endcase
  end

  // Without an accepted step everything holds, so a dropped enable freezes mid-segment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_line       <= '1;
      r_state      <= C_ST_IDLE;
      r_run_cnt    <= 8'd0;
      r_scroll_cnt <= 16'h0000;
      r_in_gap     <= 1'b0;
    end else if (w_accept) begin
      r_line    <= {w_new_bit, r_line[WIDTH-1:1]};
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
      r_in_gap  <= (w_state_nxt == C_ST_GAP);
      if (r_scroll_cnt != 16'hFFFF) begin
        r_scroll_cnt <= r_scroll_cnt + 16'h0001;
      end
    end
  end

  assign bus.line_o     = r_line;
  assign bus.in_gap     = r_in_gap;
  assign bus.scroll_cnt = r_scroll_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ground_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ground_scroller
// Brief    : Randomized bench for three ground_scroller seeds vs. a pending-run model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ground_scroller;

  localparam int W    = 640;
  localparam int LEAD = 160;
  localparam int MS   = 24;
  localparam int MG   = 8;
  localparam int N    = 3;

  logic clk;
  logic reset;
  logic step;
  logic enable_board;

  logic [W-1:0] line_obs   [N];
  logic         in_gap_obs [N];
  logic [15:0]  cnt_obs    [N];
  logic [15:0]  lfsr_obs   [N];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam logic [15:0] C_SEED = (gi == 0) ? 16'h0001 :
                                     (gi == 1) ? 16'h1234 : 16'h0000;
    ground_scroller_if #(.WIDTH(W)) bus ();
    assign bus.step         = step;
    assign bus.enable_board = enable_board;

    ground_scroller #(
      .WIDTH     (W),
      .SEED      (C_SEED),
      .LEAD_IN   (LEAD),
      .MIN_SOLID (MS),
      .MIN_GAP   (MG)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign line_obs[gi]   = bus.line_o;
    assign in_gap_obs[gi] = bus.in_gap;
    assign cnt_obs[gi]    = bus.scroll_cnt;
    assign lfsr_obs[gi]   = u_dut.u_lfsr.value;
  end

  // Model: the line plus the bits still owed by the current run.
  logic [W-1:0] m_line     [N];
  logic [15:0]  m_lfsr     [N];
  logic [15:0]  m_cnt      [N];
  bit           m_pend_bit [N];
  int           m_pend_left[N];

  bit t_last [N];
  int t_len  [N];
  int t_idx  [N];

  function automatic logic [15:0] model_seed(input int i);
    if (i == 0) return 16'h0001;
    if (i == 1) return 16'h1234;
    return 16'hACE1;
  endfunction

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (((v & 16'h1) != 0) ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_line[i]      = '1;
      m_lfsr[i]      = model_seed(i);
      m_cnt[i]       = 16'h0000;
      m_pend_bit[i]  = 1'b1;
      m_pend_left[i] = LEAD;
      t_len[i]       = 0;
      t_idx[i]       = 0;
    end
  endtask

  task automatic model_step();
    bit b;
    for (int i = 0; i < N; i++) begin
      b = m_pend_bit[i];
      m_line[i] = {b, m_line[i][W-1:1]};
      m_pend_left[i]--;
      if (m_pend_left[i] == 0) begin
        m_pend_bit[i]  = !b;
        m_pend_left[i] = b ? (MG + int'(m_lfsr[i] % 16)) : (MS + int'(m_lfsr[i] % 64));
      end
      m_lfsr[i] = galois(m_lfsr[i]);
      if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'h1;
    end
  endtask

  // Run lengths are measured from the DUT's own emitted column.
  task automatic track_runs();
    bit b;
    for (int i = 0; i < N; i++) begin
      b = line_obs[i][W-1];
      if (t_len[i] == 0) begin
        t_last[i] = b;
        t_len[i]  = 1;
      end else if (b == t_last[i]) begin
        t_len[i]++;
      end else begin
        if (t_idx[i] == 0)
          check_eq("leadin_len", t_len[i], LEAD);
        else if (t_last[i])
          check_eq("solid_len_range", (t_len[i] >= MS && t_len[i] <= MS + 63), 1);
        else
          check_eq("gap_len_range", (t_len[i] >= MG && t_len[i] <= MG + 15), 1);
        t_idx[i]++;
        t_last[i] = b;
        t_len[i]  = 1;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit e, input bit r);
    step = s; enable_board = e; reset = r;
    @(posedge clk);
    if (!r) model_reset();
    else if (s && e) model_step();
    #1;
    if (r && s && e) track_runs();
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq({tag, "_line"},   line_obs[i],   m_line[i]);
      check_eq({tag, "_in_gap"}, in_gap_obs[i], !m_pend_bit[i]);
      check_eq({tag, "_cnt"},    cnt_obs[i],    m_cnt[i]);
    end
  endtask

  task automatic check_lfsr(input string tag);
    for (int i = 0; i < N; i++) check_eq(tag, lfsr_obs[i], m_lfsr[i]);
  endtask

  initial begin
    logic [15:0] l_pre;
    int exp_gap, gap_seen, accepted, guard;
    bit done, s, e;
    n_tests = 0; n_fail = 0;
    step = 1'b0; enable_board = 1'b0; reset = 1'b0;

    for (int k = 0; k < 6; k++) cycle(k[0], 1'b1, 1'b0);
    check_all("reset");
    check_lfsr("reset_lfsr");
    check_eq("reset_lfsr_zero_seed", lfsr_obs[2], 16'hACE1);

    for (int k = 0; k < 50; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      check_all("disabled_hold");
    end

    for (int k = 0; k < LEAD; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      check_all("leadin");
    end
    check_eq("leadin_all_ones", line_obs[0], {W{1'b1}});
    check_eq("leadin_in_gap", in_gap_obs[0], 1);

    l_pre = 16'h0001;
    for (int k = 0; k < LEAD - 1; k++) l_pre = galois(l_pre);
    exp_gap = MG + int'(l_pre % 16);

    cycle(1'b1, 1'b1, 1'b1);
    check_eq("step161_msb", line_obs[0][W-1], 0);
    check_all("first_gap");
    gap_seen = 1;
    while (gap_seen < 3) begin
      cycle(1'b1, 1'b1, 1'b1);
      gap_seen++;
    end
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      check_all("freeze");
      check_lfsr("freeze_lfsr");
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      check_all("gap_resume");
      if (line_obs[0][W-1] == 1'b0) gap_seen++;
      else done = 1'b1;
    end
    check_eq("gap_done", done, 1);
    check_eq("first_gap_len", gap_seen, exp_gap);

    accepted = 0;
    for (guard = 0; guard < 20000 && accepted < 5000; guard++) begin
      s = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 15) != 0);
      cycle(s, e, 1'b1);
      if (s && e) accepted++;
      check_all("random");
    end
    check_eq("random_budget", accepted, 5000);
    check_lfsr("random_lfsr");

    cycle(1'b1, 1'b1, 1'b0);
    accepted = 0;
    for (guard = 0; guard < 1000 && !(accepted >= 300 && m_pend_bit[0]); guard++) begin
      cycle(1'b1, 1'b1, 1'b1);
      accepted++;
    end
    check_eq("reach_solid", (accepted >= 300 && m_pend_bit[0]), 1);
    cycle(1'b1, 1'b1, 1'b0);
    check_all("mid_reset");
    check_lfsr("mid_reset_lfsr");
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      check_all("post_reset");
      check_lfsr("post_reset_lfsr");
    end

    for (guard = 0; guard < 70000 && m_cnt[0] != 16'hFFFE; guard++) cycle(1'b1, 1'b1, 1'b1);
    check_eq("cnt_fffe", cnt_obs[0], 16'hFFFE);
    check_all("near_sat");
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      check_all("sat");
      check_eq("sat_cnt", cnt_obs[1], 16'hFFFF);
    end
    check_lfsr("final_lfsr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ground_scroller.md
# ground_scroller

Generates one scrolling ground line for the gravity-runner board. It holds a WIDTH-bit occupancy vector (1 = ground present at that x column) and shifts it one column toward x=0 on every `step` strobe. New terrain enters at the high end as solid runs and gaps whose lengths come from a seeded LFSR. Three instances (top, middle, bottom, distinct seeds) feed the per-player line taps consumed by `gavity_direction` and `move_player`.

## Interface

- `WIDTH`, 640, line length in columns
- `SEED`, 16'h0001, LFSR initial value; 0 is illegal and is replaced by 16'hACE1
- `LEAD_IN`, 160, length of the solid run emitted after enable, 1..255
- `MIN_SOLID`, 24, minimum solid run; MIN_SOLID+63 ≤ 255
- `MIN_GAP`, 8, minimum gap; MIN_GAP+15 ≤ 255
- `clk` input 1: system clock, the only clock
- `reset` input 1: synchronous, active-low reset
- `enable_board` input 1: level signal from `start_game`; scrolling is allowed while high
- `step` input 1: single-cycle scroll strobe at the game frame rate (80 Hz)
- `line_o` output WIDTH: ground occupancy, bit 0 = leftmost column
- `in_gap` output 1: high while the FSM is in GAP
- `scroll_cnt` output 16: count of accepted steps, saturates at 16'hFFFF

## Operation

- FSM states: IDLE, SOLID, GAP.
- Accepted step: `step`=1 and `enable_board`=1. Steps are ignored in every other case.
- On an accepted step:
  - line_o <= {new_bit, line_o[WIDTH-1:1]}; new_bit = 1 in IDLE/SOLID, 0 in GAP.
  - The LFSR advances one shift.
  - scroll_cnt increments, saturating.
- IDLE, on an accepted step:
  - Emit 1, then enter SOLID with run_cnt = LEAD_IN − 1.
  - If LEAD_IN = 1, enter GAP instead, loading the gap length as below.
- SOLID/GAP, on an accepted step:
  - Emit the state's bit.
  - If run_cnt > 1, decrement run_cnt.
  - If run_cnt = 1, switch state and load the new length from the pre-advance LFSR value L:
    - SOLID→GAP: run_cnt = MIN_GAP + L[3:0]
    - GAP→SOLID: run_cnt = MIN_SOLID + L[5:0]
- run_cnt is 8-bit and equals the bits still to emit in the current segment, including the next one.
- LFSR: 16-bit Galois, right shift, taps mask 16'hB400. It never reaches zero, because a zero seed is substituted.
- `enable_board` low while in SOLID/GAP freezes the state: line_o, state, run_cnt, LFSR and scroll_cnt all hold. It does not return to IDLE. Raising it again resumes exactly where it stopped.
- `in_gap` = (state == GAP), registered with the state.

## Timing

- Reset (`reset`=0 at a clk edge) sets:
  - line_o = all ones
  - state = IDLE
  - run_cnt = 0
  - LFSR = effective seed
  - scroll_cnt = 0
  - in_gap = 0
- Reset has priority over step. It takes effect at any point mid-operation.
- Latency: an accepted step at edge N is visible on all outputs after edge N (one cycle).
- A bit entered at column WIDTH−1 reaches column k after WIDTH−1−k further accepted steps.
- `step` held high for multiple cycles counts once per cycle. Upstream must supply a single-cycle pulse.
- A state switch and its bit emission happen in the same cycle. No bubble column is inserted.

## Structure

- Package `ground_pkg`, holding:
  - the state enum {IDLE, SOLID, GAP}
  - LFSR_TAPS = 16'hB400
  - SEED_FALLBACK = 16'hACE1
  - the function computing the effective seed
- Sub-module `lfsr16`, with inputs (clk, reset, seed, adv) and output value. It is reused by the other ground instances and later randomizers.
- The FSM, run counter and shift register live in `ground_scroller` itself.

## Test plan

- Reset with steps pulsing → line_o all ones, in_gap=0, scroll_cnt=0. After reset release with enable_board=0 and 50 steps → outputs unchanged.
- enable_board=1, LEAD_IN=160, SEED=1 → after 160 steps line_o is all ones and in_gap=1. Step 161 sets line_o[639]=0, and the gap length equals 8 + L[3:0] per the reference LFSR model.
- Run 5000 steps with SEED=16'h1234 → every solid run in the emitted stream is 24..87, every gap is 8..23, and the sequence matches the bit-exact model.
- Drop enable_board for 30 cycles mid-gap while steps continue → all outputs are held. Re-enable → the gap finishes with its original remaining length.
- Assert reset during SOLID after 300 steps → next cycle outputs equal the reset values, and the LFSR restarts from the seed. SEED=0 → behaviour is identical to SEED=16'hACE1.
- Force scroll_cnt to 16'hFFFE, then apply 3 steps → it reads 16'hFFFF and stays there.
